// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and defaults for the alu stimulus sequencer.
//   seq_state_t : sequencer FSM states (IDLE, DRIVE, RESP)
//   seq_req_t   : request record {vec, count} at the default count width
//   SEQ_DEPTH / SEQ_COUNT_W : default request FIFO depth and count width
package alu_seq_pkg;

  localparam int SEQ_DEPTH   = 4;
  localparam int SEQ_COUNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [3:0]             vec;
    logic [SEQ_COUNT_W-1:0] count;
  } seq_req_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous FIFO, async active-low reset.
//   clock, reset_n : clock / async reset
//   push, din      : write strobe and data (ignored while full)
//   pop, dout      : read strobe (ignored while empty); dout shows the head entry
//   full, empty    : occupancy flags, decoded from the entry count
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset: occupancy is tracked by cnt alone.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/alu_stim_sequencer.sv
// alu_stim_sequencer: queues stimulus requests and replays each 4-bit vector
// onto the alu for N cycles, counting cycles with alu_po0 high.
//   clock, reset_n        : clock / async active-low reset
//   req_valid/req_ready   : request handshake; req_ready = FIFO not full
//   req_vec, req_count    : vector {pi3..pi0} and burst length (0 means 1)
//   alu_pi                : registered drive to the alu, IDLE_VEC between bursts
//   alu_po0               : alu output, sampled on every DRIVE cycle
//   rsp_valid/rsp_ready   : response handshake, one response per request
//   rsp_hits              : DRIVE cycles that saw alu_po0 = 1
//   rsp_first             : (ALU_SEQ_FIRST_HIT_EN only) 0-based index of the
//                           first hit, all-ones when there was none
//   busy                  : state not IDLE or FIFO non-empty
// Optional feature macro: ALU_SEQ_FIRST_HIT_EN.
module alu_stim_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         DEPTH    = SEQ_DEPTH,
  parameter int         COUNT_W  = SEQ_COUNT_W,
  parameter logic [3:0] IDLE_VEC = 4'b0000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_vec,
  input  logic [COUNT_W-1:0] req_count,
  output logic [3:0]         alu_pi,
  input  logic               alu_po0,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [COUNT_W-1:0] rsp_hits,
`ifdef ALU_SEQ_FIRST_HIT_EN
  output logic [COUNT_W-1:0] rsp_first,
`endif
  output logic               busy
);

  // Request record at the configured count width.
  typedef struct packed {
    logic [3:0]         vec;
    logic [COUNT_W-1:0] count;
  } req_t;

  req_t               fifo_din, fifo_dout;
  logic               fifo_full, fifo_empty;
  logic               pop;
  seq_state_t         state;
  logic [COUNT_W-1:0] remaining;
  logic [COUNT_W-1:0] hits;

  assign fifo_din  = {req_vec, req_count};
  assign req_ready = !fifo_full;
  // The FIFO count is registered, so a push into an empty FIFO is seen
  // (and popped) one cycle later.
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  // hits is frozen from the last DRIVE edge until the next pop.
  assign rsp_hits  = hits;

  alu_seq_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(req_t))
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (req_valid && req_ready),
    .din    (fifo_din),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      alu_pi    <= IDLE_VEC;
      rsp_valid <= 1'b0;
      remaining <= '0;
      hits      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_pi    <= fifo_dout.vec;
            remaining <= (fifo_dout.count == '0) ? COUNT_W'(1) : fifo_dout.count;
            hits      <= '0;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          hits      <= hits + COUNT_W'(alu_po0);
          remaining <= remaining - COUNT_W'(1);
          // Last driven cycle: release the alu on the same edge.
          if (remaining == COUNT_W'(1)) begin
            alu_pi    <= IDLE_VEC;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Always back through IDLE, which leaves one idle cycle between bursts.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_FIRST_HIT_EN
  logic [COUNT_W-1:0] first_q;
  logic [COUNT_W-1:0] idx_q;

  // Index stays below 2^COUNT_W-1, so all-ones is free to mean "no hit".
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      first_q <= '1;
      idx_q   <= '0;
    end else if (pop) begin
      first_q <= '1;
      idx_q   <= '0;
    end else if (state == ST_DRIVE) begin
      idx_q <= idx_q + COUNT_W'(1);
      if (alu_po0 && (hits == '0)) first_q <= idx_q;
    end
  end

  assign rsp_first = first_q;
`endif

endmodule
